mhp_rx_parser: RTL and testbench

- Receive-side counterpart of the MHP request builder/sender.
- Pops bytes from the Ethernet RX payload FIFO and parses the MHP frame: dst(16), src(16), size(16), dir/type(8), payload(size bytes), scs(16).
- Stores the payload in a local BRAM and verifies the checksum.
- Presents the parsed header, payload read port and status to the control FSM, and holds them until acknowledged.

---
 rtl/mhp_pkg.sv | 25 ++
 rtl/mhp_rx_parser_if.sv | 33 +++
 rtl/mhp_pl_ram.sv | 35 +++
 rtl/mhp_rx_parser.sv | 189 ++++++++++++++++++
 tb/tb_mhp_rx_parser.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mhp_pkg.sv
// rtl/mhp_pkg.sv - shared MHP frame constants, error codes and parser state encoding
package mhp_pkg;

  localparam int          HDR_LEN    = 7;
  localparam int          SCS_LEN    = 2;
  localparam logic [15:0] BCAST_ADDR = 16'hFFFF;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_SCS   = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_TRUNC = 2'd3;

  // Request-address type code, common to the sender and receiver
  localparam logic [6:0] TYPE_REQ_ADDR = 7'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_SCS     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/mhp_rx_parser_if.sv
// rtl/mhp_rx_parser_if.sv - RX FIFO, parsed-frame and payload-read signals of the MHP parser
interface mhp_rx_parser_if #(
  parameter int PL_AW = 8
) ();

  logic [7:0]       i_rdata;
  logic             i_rready;
  logic             o_rreq;
  logic             o_valid;
  logic             i_ack;
  logic [15:0]      o_dst_addr;
  logic [15:0]      o_src_addr;
  logic [15:0]      o_size;
  logic             o_dir;
  logic [6:0]       o_type;
  logic             o_addr_match;
  logic [1:0]       o_err;
  logic [PL_AW-1:0] i_pl_raddr;
  logic [7:0]       o_pl_rdata;

  modport master (
    input  i_rdata, i_rready, i_ack, i_pl_raddr,
    output o_rreq, o_valid, o_dst_addr, o_src_addr, o_size, o_dir, o_type,
           o_addr_match, o_err, o_pl_rdata
  );

  modport slave (
    output i_rdata, i_rready, i_ack, i_pl_raddr,
    input  o_rreq, o_valid, o_dst_addr, o_src_addr, o_size, o_dir, o_type,
           o_addr_match, o_err, o_pl_rdata
  );

endinterface

// File: rtl/mhp_pl_ram.sv
// rtl/mhp_pl_ram.sv - payload buffer: one write port, one registered read port
module mhp_pl_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is cleared; the array keeps its contents
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mhp_rx_parser.sv
// rtl/mhp_rx_parser.sv - parses MHP frames from the RX FIFO, buffers the payload,
// verifies the checksum and holds the result until acknowledged
module mhp_rx_parser
  import mhp_pkg::*;
#(
  parameter logic [15:0] MY_ADDR     = 16'h0001,
  parameter int          MAX_PAYLOAD = 256,
  parameter int          PL_AW       = 8,
  parameter int          TIMEOUT     = 62
) (
  input logic          i_clk,
  input logic          i_rst,
  mhp_rx_parser_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e          state_q;
  logic [TW-1:0]   tmo_q;
  logic [2:0]      idx_q;
  logic [15:0]     pl_cnt_q;
  logic [15:0]     dst_q;
  logic [15:0]     src_q;
  logic [15:0]     size_q;
  logic [7:0]      type_q;
  logic [15:0]     csum_q;
  logic [7:0]      scs_hi_q;
  logic [1:0]      err_q;
  logic            valid_q;

  logic [7:0]      rx_byte;
  logic            pop;
  logic            active;
  logic            tmo_hit;
  logic [15:0]     csum_nxt;
  logic [15:0]     rx_scs;

  assign rx_byte  = bus.i_rdata;
  assign active   = (state_q == ST_HDR) || (state_q == ST_PAYLOAD) ||
                    (state_q == ST_SCS) || (state_q == ST_DRAIN);
  assign pop      = bus.i_rready & (state_q != ST_DONE);
  assign tmo_hit  = active & ~bus.i_rready & (tmo_q == TW'(TIMEOUT - 1));
  assign csum_nxt = csum_q + {8'h00, rx_byte};
  assign rx_scs   = {scs_hi_q, rx_byte};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      idx_q    <= 3'd0;
      pl_cnt_q <= 16'd0;
      dst_q    <= 16'd0;
      src_q    <= 16'd0;
      size_q   <= 16'd0;
      type_q   <= 8'd0;
      csum_q   <= 16'd0;
      scs_hi_q <= 8'd0;
      err_q    <= ERR_OK;
      valid_q  <= 1'b0;
    end else begin
      if (pop || !active) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            dst_q   <= {rx_byte, 8'h00};
            src_q   <= 16'd0;
            size_q  <= 16'd0;
            type_q  <= 8'd0;
            csum_q  <= {8'h00, rx_byte};
            idx_q   <= 3'd1;
            err_q   <= ERR_OK;
            state_q <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (pop) begin
            csum_q <= csum_nxt;
            idx_q  <= idx_q + 3'd1;
            if (idx_q == 3'(HDR_LEN - 1)) begin
              type_q <= rx_byte;
              if (size_q > 16'(MAX_PAYLOAD)) begin
                err_q   <= ERR_LEN;
                state_q <= ST_DRAIN;
              end else if (size_q == 16'd0) begin
                idx_q   <= 3'd0;
                state_q <= ST_SCS;
              end else begin
                pl_cnt_q <= 16'd0;
                state_q  <= ST_PAYLOAD;
              end
            end else begin
              case (idx_q)
                3'd1:    dst_q[7:0]   <= rx_byte;
                3'd2:    src_q[15:8]  <= rx_byte;
                3'd3:    src_q[7:0]   <= rx_byte;
                3'd4:    size_q[15:8] <= rx_byte;
                default: size_q[7:0]  <= rx_byte;
              endcase
            end
          end else if (tmo_hit) begin
            err_q   <= ERR_TRUNC;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_PAYLOAD: begin
          if (pop) begin
            csum_q   <= csum_nxt;
            pl_cnt_q <= pl_cnt_q + 16'd1;
            if (pl_cnt_q == size_q - 16'd1) begin
              idx_q   <= 3'd0;
              state_q <= ST_SCS;
            end
          end else if (tmo_hit) begin
            err_q   <= ERR_TRUNC;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_SCS: begin
          if (pop) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'(SCS_LEN - 1)) begin
              err_q   <= (rx_scs != csum_q) ? ERR_SCS : ERR_OK;
              state_q <= ST_DRAIN;
            end else begin
              scs_hi_q <= rx_byte;
            end
          end else if (tmo_hit) begin
            err_q   <= ERR_TRUNC;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        // Padding and trailing garbage are swallowed until the line goes quiet
        ST_DRAIN: begin
          if (tmo_hit) begin
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (bus.i_ack) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mhp_pl_ram #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (PL_AW)
  ) u_pl_ram (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .we_i    (pop && (state_q == ST_PAYLOAD)),
    .waddr_i (pl_cnt_q[PL_AW-1:0]),
    .wdata_i (rx_byte),
    .raddr_i (bus.i_pl_raddr),
    .rdata_o (bus.o_pl_rdata)
  );

  assign bus.o_rreq       = pop;
  assign bus.o_valid      = valid_q;
  assign bus.o_dst_addr   = dst_q;
  assign bus.o_src_addr   = src_q;
  assign bus.o_size       = size_q;
  assign bus.o_dir        = type_q[7];
  assign bus.o_type       = type_q[6:0];
  assign bus.o_addr_match = (dst_q == MY_ADDR) || (dst_q == BCAST_ADDR);
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_mhp_rx_parser.sv
// tb/tb_mhp_rx_parser.sv - self-checking bench for mhp_rx_parser
module tb_mhp_rx_parser;
  import mhp_pkg::*;

  localparam logic [15:0] MY     = 16'h0001;
  localparam int          MAXPL  = 256;
  localparam int          TMO    = 62;

  typedef struct {
    logic [15:0] dst;
    logic [15:0] src;
    logic [15:0] size;
    logic        dir;
    logic [6:0]  typ;
    logic        match;
    logic [1:0]  err;
  } exp_t;

  typedef struct {
    int           len;
    logic [255:0] bytes;
    exp_t         e;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] fifo[$];
  vec_t vecs[$];

  mhp_rx_parser_if #(.PL_AW(8)) bus ();

  mhp_rx_parser #(
    .MY_ADDR     (MY),
    .MAX_PAYLOAD (MAXPL),
    .PL_AW       (8),
    .TIMEOUT     (TMO)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Show-ahead FIFO model: pop on the edge, present the new head at the falling edge
  always @(posedge i_clk) begin
    if (!i_rst && bus.o_rreq && bus.i_rready && fifo.size() > 0) begin
      void'(fifo.pop_front());
    end
  end

  always @(negedge i_clk) begin
    bus.i_rready = (fifo.size() > 0);
    bus.i_rdata  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] q[$]);
    exp_t        e;
    int          s;
    logic [15:0] sum;
    e.dst   = {q[0], q[1]};
    e.src   = {q[2], q[3]};
    e.size  = {q[4], q[5]};
    e.dir   = q[6][7];
    e.typ   = q[6][6:0];
    e.match = (e.dst == MY) || (e.dst == 16'hFFFF);
    s = int'(e.size);
    if (s > MAXPL) begin
      e.err = 2'd2;
    end else if (q.size() < 7 + s + 2) begin
      e.err = 2'd3;
    end else begin
      sum = 16'd0;
      for (int i = 0; i < 7 + s; i++) sum = sum + {8'h00, q[i]};
      e.err = (sum == {q[7+s], q[8+s]}) ? 2'd0 : 2'd1;
    end
    return e;
  endfunction

  task automatic add_vec(input int len, input logic [255:0] b,
                         input logic [15:0] dst, input logic [15:0] src, input logic [15:0] size,
                         input logic dir, input logic [6:0] typ, input logic m, input logic [1:0] err);
    vec_t v;
    v.len = len; v.bytes = b;
    v.e.dst = dst; v.e.src = src; v.e.size = size; v.e.dir = dir;
    v.e.typ = typ; v.e.match = m; v.e.err = err;
    vecs.push_back(v);
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int cyc = 0;
    while (!bus.o_valid && cyc < bound) begin
      @(negedge i_clk);
      cyc++;
    end
    if (!bus.o_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s valid_timeout: o_valid still 0 after %0d cycles", tag, bound);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] q[$], input exp_t e, input bit push_it);
    if (push_it) begin
      foreach (q[i]) fifo.push_back(q[i]);
    end
    wait_valid(tag, q.size() + TMO + 40);
    chk({tag, " valid"}, 32'(bus.o_valid), 32'd1);
    chk({tag, " dst"},   32'(bus.o_dst_addr), 32'(e.dst));
    chk({tag, " src"},   32'(bus.o_src_addr), 32'(e.src));
    chk({tag, " size"},  32'(bus.o_size), 32'(e.size));
    chk({tag, " dir"},   32'(bus.o_dir), 32'(e.dir));
    chk({tag, " type"},  32'(bus.o_type), 32'(e.typ));
    chk({tag, " match"}, 32'(bus.o_addr_match), 32'(e.match));
    chk({tag, " err"},   32'(bus.o_err), 32'(e.err));
    chk({tag, " all_popped"}, 32'(fifo.size()), 32'd0);
    if (e.err <= 2'd1) begin
      for (int i = 0; i < int'(e.size); i++) begin
        bus.i_pl_raddr = 8'(i);
        @(negedge i_clk);
        chk($sformatf("%s payload[%0d]", tag, i), 32'(bus.o_pl_rdata), 32'(q[7+i]));
      end
    end
    bus.i_ack = 1'b1;
    @(negedge i_clk);
    bus.i_ack = 1'b0;
    chk({tag, " valid_after_ack"}, 32'(bus.o_valid), 32'd0);
  endtask

  task automatic vec_to_q(input vec_t v, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < v.len; i++) q.push_back(v.bytes[8*(v.len-1-i) +: 8]);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] q2[$];
    exp_t       e;
    int         sz;
    int         total;
    int         cyc;
    logic [15:0] sum;

    bus.i_ack      = 1'b0;
    bus.i_pl_raddr = 8'h00;
    bus.i_rready   = 1'b0;
    bus.i_rdata    = 8'h00;

    add_vec(11, 256'hFFFF0001000283AABB03E9, 16'hFFFF, 16'h0001, 16'd2, 1'b1, TYPE_REQ_ADDR, 1'b1, 2'd0);
    add_vec(11, 256'hFFFF0001000283AABB03EA, 16'hFFFF, 16'h0001, 16'd2, 1'b1, TYPE_REQ_ADDR, 1'b1, 2'd1);
    add_vec(17, 256'h00010002020003_0102030405060708090A, 16'h0001, 16'h0002, 16'h0200, 1'b0, 7'h03, 1'b1, 2'd2);
    add_vec(12, 256'h00010003000803_1122334455, 16'h0001, 16'h0003, 16'd8, 1'b0, 7'h03, 1'b1, 2'd3);
    add_vec(9,  256'h00010004000005_000A, 16'h0001, 16'h0004, 16'd0, 1'b0, 7'h05, 1'b1, 2'd0);
    add_vec(10, 256'h12340001000183_7F_014A, 16'h1234, 16'h0001, 16'd1, 1'b1, 7'h03, 1'b0, 2'd0);

    repeat (3) @(negedge i_clk);
    chk("reset valid", 32'(bus.o_valid), 32'd0);
    chk("reset err",   32'(bus.o_err), 32'd0);
    chk("reset dst",   32'(bus.o_dst_addr), 32'd0);
    chk("reset size",  32'(bus.o_size), 32'd0);
    chk("reset rdata", 32'(bus.o_pl_rdata), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    foreach (vecs[k]) begin
      vec_to_q(vecs[k], q);
      check_frame($sformatf("vec%0d", k), q, vecs[k].e, 1'b1);
      repeat (2) @(negedge i_clk);
    end

    // Non-matching frame with padding; the next frame waits in the FIFO during DONE
    q = '{8'h00, 8'h05, 8'h00, 8'h01, 8'h00, 8'h01, 8'h03, 8'h42, 8'h00, 8'h4C};
    for (int i = 0; i < 30; i++) q.push_back(8'hEE);
    foreach (q[i]) fifo.push_back(q[i]);
    cyc = 0;
    while (fifo.size() > 0 && cyc < 200) begin @(negedge i_clk); cyc++; end
    repeat (70) @(negedge i_clk);
    vec_to_q(vecs[0], q2);
    foreach (q2[i]) fifo.push_back(q2[i]);
    repeat (3) @(negedge i_clk);
    chk("pad valid", 32'(bus.o_valid), 32'd1);
    chk("pad match", 32'(bus.o_addr_match), 32'd0);
    chk("pad err",   32'(bus.o_err), 32'd0);
    chk("pad dst",   32'(bus.o_dst_addr), 32'h0005);
    chk("pad rreq_in_done", 32'(bus.o_rreq), 32'd0);
    chk("pad fifo_held", 32'(fifo.size()), 32'(q2.size()));
    bus.i_ack = 1'b1;
    @(negedge i_clk);
    bus.i_ack = 1'b0;
    chk("pad valid_after_ack", 32'(bus.o_valid), 32'd0);
    chk("pad no_pop_on_ack", 32'(fifo.size()), 32'(q2.size()));
    check_frame("second", q2, vecs[0].e, 1'b0);

    // Asynchronous reset in the middle of the payload
    q = '{8'h00, 8'h01, 8'h00, 8'h07, 8'h00, 8'd20, 8'h03};
    for (int i = 0; i < 22; i++) q.push_back(8'(i + 1));
    total = q.size();
    foreach (q[i]) fifo.push_back(q[i]);
    cyc = 0;
    while (fifo.size() > total - 12 && cyc < 100) begin @(negedge i_clk); cyc++; end
    chk("rst pre_dst", 32'(bus.o_dst_addr), 32'h0001);
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst valid", 32'(bus.o_valid), 32'd0);
    chk("rst dst",   32'(bus.o_dst_addr), 32'd0);
    chk("rst size",  32'(bus.o_size), 32'd0);
    fifo.delete();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    vec_to_q(vecs[0], q);
    check_frame("post_rst", q, vecs[0].e, 1'b1);

    // Randomized frames against the reference model
    for (int f = 0; f < 40; f++) begin
      q = {};
      case ($urandom_range(0, 2))
        0:       begin q.push_back(8'h00); q.push_back(8'h01); end
        1:       begin q.push_back(8'hFF); q.push_back(8'hFF); end
        default: begin q.push_back(8'($urandom)); q.push_back(8'($urandom)); end
      endcase
      q.push_back(8'($urandom)); q.push_back(8'($urandom));
      sz = ($urandom_range(0, 9) == 0) ? 257 + $urandom_range(0, 100) : $urandom_range(0, 24);
      q.push_back(8'(sz >> 8)); q.push_back(8'(sz));
      q.push_back(8'($urandom));
      if (sz <= MAXPL) begin
        for (int i = 0; i < sz; i++) q.push_back(8'($urandom));
        sum = 16'd0;
        foreach (q[i]) sum = sum + {8'h00, q[i]};
        if ($urandom_range(0, 3) == 0) sum = sum ^ 16'(1 << $urandom_range(0, 15));
        q.push_back(sum[15:8]); q.push_back(sum[7:0]);
        if ($urandom_range(0, 7) == 0) begin
          total = $urandom_range(7, q.size() - 1);
          while (q.size() > total) void'(q.pop_back());
        end else begin
          for (int i = $urandom_range(0, 4); i > 0; i--) q.push_back(8'($urandom));
        end
      end else begin
        for (int i = $urandom_range(0, 6); i > 0; i--) q.push_back(8'($urandom));
      end
      e = model(q);
      check_frame($sformatf("rand%0d", f), q, e, 1'b1);
      @(negedge i_clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
